// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC layer sequencer.
// Contents: FSM state encoding, datapath widths, and the DRAIN watchdog
// timeout. WD_W is the watchdog counter width derived from TIMEOUT.
package mac_seq_pkg;

    localparam int BEAT_W  = 8;
    localparam int IDX_W   = 10;
    localparam int RES_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int WD_W    = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLR    = 4'd1,
        BIAS   = 4'd2,
        STREAM = 4'd3,
        DRAIN  = 4'd4,
        READ   = 4'd5,
        CAPT   = 4'd6,
        OUT    = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage

// File: rtl/mac_seq_watchdog.sv
// DRAIN-phase watchdog.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   arm      : high while the sequencer waits for the datapath
//   kick     : datapath completion; suppresses expiry in the same cycle
//   expired  : high in the TIMEOUT-th consecutive armed cycle with no kick
module mac_seq_watchdog
    import mac_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic kick,
    output logic expired
);

    logic [WD_W-1:0] cnt_r;

    // Counts armed cycles; restarts whenever disarmed or kicked, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= WD_W'(0);
        end else if (!arm || kick) begin
            cnt_r <= WD_W'(0);
        end else if (cnt_r != WD_W'(TIMEOUT - 1)) begin
            cnt_r <= cnt_r + WD_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // cnt_r equals the number of armed cycles already spent, so the limit is
    // reached during the TIMEOUT-th armed cycle.
    assign expired = arm && !kick && (cnt_r == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/mac_layer_sequencer.sv
// Layer sequencer for a MAC datapath: for every output neuron it clears the
// accumulator, fetches the bias, streams cfg_beats DMA beats, waits for the
// datapath, reads and captures the result and hands it downstream.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   start, cfg_beats, cfg_neurons,
//   cfg_op_mode                      : layer launch and configuration
//   dma_valid / dma_ready            : DMA beat handshake
//   bias_req, bias_addr, bias_valid  : bias fetch
//   mac_en, mac_clr, mac_read_en,
//   mac_op_mode, mac_done, mac_result: datapath control and status
//   out_valid, out_data, out_index,
//   out_ready                        : result word handshake
//   busy, layer_done, err            : status
// Only dma_ready and mac_en are combinational; every other output is
// registered from the next state so it lines up with the state it belongs to.
module mac_layer_sequencer
    import mac_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BEAT_W-1:0] cfg_beats,
    input  logic [IDX_W-1:0]  cfg_neurons,
    input  logic              cfg_op_mode,
    input  logic              dma_valid,
    output logic              dma_ready,
    output logic              bias_req,
    output logic [IDX_W-1:0]  bias_addr,
    input  logic              bias_valid,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mac_read_en,
    output logic              mac_op_mode,
    input  logic              mac_done,
    input  logic [RES_W-1:0]  mac_result,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_index,
    input  logic              out_ready,
    output logic              busy,
    output logic              layer_done,
    output logic              err
);

    state_t            state_r, state_s;
    logic [BEAT_W-1:0] beat_cnt_r, cfg_beats_r;
    logic [IDX_W-1:0]  index_r, index_s, cfg_neurons_r;
    logic              op_mode_r, op_mode_s, err_s;
    logic              last_beat_s, last_neuron_s, cfg_zero_s;
    logic              wd_arm_s, wd_expired_s;

    assign dma_ready     = (state_r == STREAM);
    assign mac_en        = dma_valid & dma_ready;
    assign last_beat_s   = ((beat_cnt_r + BEAT_W'(1)) == cfg_beats_r);
    assign last_neuron_s = (index_r == (cfg_neurons_r - IDX_W'(1)));
    assign cfg_zero_s    = (cfg_beats == BEAT_W'(0)) || (cfg_neurons == IDX_W'(0));
    assign wd_arm_s      = (state_r == DRAIN);

    mac_seq_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .arm     (wd_arm_s),
        .kick    (mac_done),
        .expired (wd_expired_s)
    );

    // Next-state, next-index, latched op mode and sticky error.
    always_comb begin
        state_s   = state_r;
        index_s   = index_r;
        op_mode_s = op_mode_r;
        err_s     = err;
        case (state_r)
            IDLE: begin
                if (start) begin
                    op_mode_s = cfg_op_mode;
                    index_s   = IDX_W'(0);
                    err_s     = cfg_zero_s;
                    state_s   = cfg_zero_s ? DONE : CLR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: state_s = BIAS;
            BIAS: begin
                if (bias_valid) begin
                    state_s = STREAM;
                end else begin
                    state_s = BIAS;
                end
            end
            STREAM: begin
                if (mac_en && last_beat_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                // A late mac_done in the expiry cycle still wins.
                if (mac_done) begin
                    state_s = READ;
                end else if (wd_expired_s) begin
                    err_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            READ: state_s = CAPT;
            CAPT: state_s = OUT;
            OUT: begin
                // out_valid is high for the whole of OUT, so out_ready alone completes the handshake.
                if (out_ready) begin
                    if (last_neuron_s) begin
                        state_s = DONE;
                    end else begin
                        index_s = index_r + IDX_W'(1);
                        state_s = CLR;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            DONE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, counters, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            beat_cnt_r    <= BEAT_W'(0);
            cfg_beats_r   <= BEAT_W'(0);
            cfg_neurons_r <= IDX_W'(0);
            index_r       <= IDX_W'(0);
            op_mode_r     <= 1'b0;
            err           <= 1'b0;
            bias_req      <= 1'b0;
            bias_addr     <= IDX_W'(0);
            mac_clr       <= 1'b0;
            mac_read_en   <= 1'b0;
            mac_op_mode   <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= RES_W'(0);
            out_index     <= IDX_W'(0);
            busy          <= 1'b0;
            layer_done    <= 1'b0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            op_mode_r <= op_mode_s;
            err       <= err_s;
            if (state_r == IDLE && start) begin
                cfg_beats_r   <= cfg_beats;
                cfg_neurons_r <= cfg_neurons;
            end
            if (state_r == CLR) begin
                beat_cnt_r <= BEAT_W'(0);
            end else if (mac_en && (beat_cnt_r != {BEAT_W{1'b1}})) begin
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
            if (state_r == CAPT) begin
                out_data  <= mac_result;
                out_index <= index_r;
            end
            bias_req    <= (state_s == BIAS);
            bias_addr   <= index_s;
            mac_clr     <= (state_s == CLR);
            mac_read_en <= (state_s == READ);
            // Kept low in DONE so an aborted or empty layer drives no datapath control.
            mac_op_mode <= ((state_s != IDLE) && (state_s != DONE)) ? op_mode_s : 1'b0;
            out_valid   <= (state_s == OUT);
            busy        <= (state_s != IDLE);
            layer_done  <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
module tb_mac_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, cfg_op_mode;
    logic [7:0]  cfg_beats;
    logic [9:0]  cfg_neurons;
    logic        dma_valid, dma_ready, bias_req, bias_valid;
    logic [9:0]  bias_addr, out_index;
    logic        mac_en, mac_clr, mac_read_en, mac_op_mode, mac_done;
    logic [15:0] mac_result, out_data;
    logic        out_valid, out_ready, busy, layer_done, err;

    mac_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_beats(cfg_beats),
        .cfg_neurons(cfg_neurons), .cfg_op_mode(cfg_op_mode),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .bias_req(bias_req),
        .bias_addr(bias_addr), .bias_valid(bias_valid), .mac_en(mac_en),
        .mac_clr(mac_clr), .mac_read_en(mac_read_en), .mac_op_mode(mac_op_mode),
        .mac_done(mac_done), .mac_result(mac_result), .out_valid(out_valid),
        .out_data(out_data), .out_index(out_index), .out_ready(out_ready),
        .busy(busy), .layer_done(layer_done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    int          vcyc_q[$];
    int          hs_q[$];
    int          done_cyc, n_en, misalign, last_acc, clr_cnt, bias_cnt;
    int          stab_bad, clr_wait, op_bad, bias_addr_bad, ready_after_last;
    logic        done_err;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        start = 1'b0; cfg_beats = 8'd0; cfg_neurons = 10'd0; cfg_op_mode = 1'b0;
        dma_valid = 1'b0; bias_valid = 1'b0; mac_done = 1'b0;
        mac_result = 16'd0; out_ready = 1'b0;
    endtask

    // Plays the environment for one layer and records what the DUT did.
    task automatic run_layer(input int beats, input int neurons, input logic op,
                             input logic [15:0] res, input int hold, input bit toggle,
                             input bit give_done, input int budget);
        int acc, waitc, hs;
        bit done_flag, pat;
        logic prev_valid;
        logic [15:0] held_data;
        logic [9:0] held_idx;
        obs_q.delete(); vcyc_q.delete(); hs_q.delete();
        done_cyc = -1; n_en = 0; misalign = 0; last_acc = -10; clr_cnt = 0;
        bias_cnt = 0; stab_bad = 0; clr_wait = 0; op_bad = 0; bias_addr_bad = 0;
        ready_after_last = -1; done_err = 1'bx;
        acc = 0; waitc = 0; hs = 0; done_flag = 1'b0; pat = 1'b1;
        prev_valid = 1'b0; held_data = 16'd0; held_idx = 10'd0;
        idle_inputs();
        tick();
        cyc = 0;
        cfg_beats = 8'(beats); cfg_neurons = 10'(neurons); cfg_op_mode = op;
        mac_result = res; start = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            start = 1'b0;
            if (layer_done) begin
                done_cyc = cyc;
                done_err = err;
                break;
            end
            if (mac_clr) begin clr_cnt++; acc = 0; end
            if (bias_req) begin
                bias_cnt++;
                if (bias_addr !== 10'(hs)) bias_addr_bad++;
            end
            if (busy && mac_op_mode !== op) op_bad++;
            if (out_valid && mac_clr) clr_wait++;
            if (out_valid && !prev_valid) vcyc_q.push_back(cyc);
            if (out_valid && prev_valid && (out_data !== held_data || out_index !== held_idx)) stab_bad++;
            prev_valid = out_valid; held_data = out_data; held_idx = out_index;
            if (cyc == last_acc + 1) ready_after_last = int'(dma_ready);
            bias_valid = bias_req;
            mac_done = give_done && done_flag;
            done_flag = 1'b0;
            if (dma_ready) begin
                dma_valid = toggle ? pat : 1'b1;
                pat = ~pat;
            end else begin
                dma_valid = 1'b0;
            end
            mac_result = res + 16'(hs);
            out_ready = out_valid && (waitc >= hold);
            if (out_valid && !out_ready) waitc++;
            #1;
            if (mac_en) n_en++;
            if (mac_en !== (dma_valid & dma_ready)) misalign++;
            if (mac_en) begin
                acc++;
                if (acc == beats) begin last_acc = cyc; done_flag = 1'b1; end
            end
            if (out_valid && out_ready) begin
                obs_q.push_back({out_index, out_data});
                hs_q.push_back(cyc);
                hs++;
                waitc = 0;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; start = 1'b1; cfg_beats = 8'd4; cfg_neurons = 10'd2;
        tick(); tick();
        vectors++;
        if ({busy, out_valid, layer_done, err, dma_ready, mac_en, mac_clr, bias_req, mac_read_en, mac_op_mode} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0", {busy, out_valid, layer_done, err, dma_ready, mac_en, mac_clr, bias_req, mac_read_en, mac_op_mode});
        end
        vectors++;
        if ({out_data, out_index, bias_addr} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {out_data, out_index, bias_addr});
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        exp_q.push_back({10'd0, 16'hA000});
        exp_q.push_back({10'd1, 16'hA001});
        run_layer(4, 2, 1'b1, 16'hA000, 0, 1'b0, 1'b1, 100);
        vectors++;
        if (obs_q.size() != 2) begin miscompares++; $display("FAIL basic_count: got %0d expected 2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            logic [25:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 26'h3FFFFFF;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL basic_word: got %h expected %h", o, e); end
        end
        vectors++;
        if ((vcyc_q.size() > 0 ? vcyc_q[0] : -1) != 10) begin miscompares++; $display("FAIL basic_latency: got %0d expected 10", vcyc_q.size() > 0 ? vcyc_q[0] : -1); end
        vectors++;
        if ((vcyc_q.size() > 1 ? vcyc_q[1] - vcyc_q[0] : -1) != 10) begin miscompares++; $display("FAIL basic_spacing: got %0d expected 10", vcyc_q.size() > 1 ? vcyc_q[1] - vcyc_q[0] : -1); end
        vectors++;
        if (done_cyc != (hs_q.size() > 1 ? hs_q[1] + 1 : -5)) begin miscompares++; $display("FAIL basic_done: got %0d expected %0d", done_cyc, hs_q.size() > 1 ? hs_q[1] + 1 : -5); end
        vectors++;
        if (done_err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b expected 0", done_err); end
        vectors++;
        if (op_bad != 0 || bias_addr_bad != 0 || clr_cnt != 2) begin
            miscompares++;
            $display("FAIL basic_ctrl: got op_bad=%0d bias_addr_bad=%0d clr=%0d expected 0/0/2", op_bad, bias_addr_bad, clr_cnt);
        end
    endtask

    task automatic test_toggle();
        exp_q.push_back({10'd0, 16'h0042});
        run_layer(3, 1, 1'b0, 16'h0042, 0, 1'b1, 1'b1, 100);
        vectors++;
        if (n_en != 3) begin miscompares++; $display("FAIL toggle_en_count: got %0d expected 3", n_en); end
        vectors++;
        if (misalign != 0) begin miscompares++; $display("FAIL toggle_align: got %0d expected 0", misalign); end
        vectors++;
        if (last_acc != 7) begin miscompares++; $display("FAIL toggle_last_accept: got %0d expected 7", last_acc); end
        vectors++;
        if (ready_after_last != 0) begin miscompares++; $display("FAIL toggle_drain_entry: got %0d expected 0", ready_after_last); end
        vectors++;
        if ((vcyc_q.size() > 0 ? vcyc_q[0] : -1) != last_acc + 4) begin miscompares++; $display("FAIL toggle_out_cycle: got %0d expected %0d", vcyc_q.size() > 0 ? vcyc_q[0] : -1, last_acc + 4); end
        while (exp_q.size() > 0) begin
            logic [25:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 26'h3FFFFFF;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL toggle_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        exp_q.push_back({10'd0, 16'h1234});
        exp_q.push_back({10'd1, 16'h1235});
        run_layer(2, 2, 1'b0, 16'h1234, 5, 1'b0, 1'b1, 100);
        vectors++;
        if ((hs_q.size() > 0 && vcyc_q.size() > 0 ? hs_q[0] - vcyc_q[0] : -1) != 5) begin miscompares++; $display("FAIL bp_hold: got %0d expected 5", hs_q.size() > 0 && vcyc_q.size() > 0 ? hs_q[0] - vcyc_q[0] : -1); end
        vectors++;
        if (stab_bad != 0) begin miscompares++; $display("FAIL bp_stable: got %0d expected 0", stab_bad); end
        vectors++;
        if (clr_wait != 0) begin miscompares++; $display("FAIL bp_early_clr: got %0d expected 0", clr_wait); end
        vectors++;
        if ((vcyc_q.size() > 1 && hs_q.size() > 0 ? vcyc_q[1] - hs_q[0] : -1) != 8) begin miscompares++; $display("FAIL bp_next_neuron: got %0d expected 8", vcyc_q.size() > 1 && hs_q.size() > 0 ? vcyc_q[1] - hs_q[0] : -1); end
        while (exp_q.size() > 0) begin
            logic [25:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 26'h3FFFFFF;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL bp_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_watchdog();
        run_layer(4, 1, 1'b0, 16'h5555, 0, 1'b0, 1'b0, 200);
        vectors++;
        if (done_cyc - (last_acc + 1) != 64) begin miscompares++; $display("FAIL wd_timeout: got %0d expected 64", done_cyc - (last_acc + 1)); end
        vectors++;
        if (done_err !== 1'b1) begin miscompares++; $display("FAIL wd_err: got %b expected 1", done_err); end
        vectors++;
        if (vcyc_q.size() != 0 || obs_q.size() != 0) begin miscompares++; $display("FAIL wd_no_output: got %0d expected 0", vcyc_q.size()); end
        tick();
        vectors++;
        if ({err, busy} !== 2'b10) begin miscompares++; $display("FAIL wd_sticky: got %b expected 10", {err, busy}); end
    endtask

    task automatic test_reset_mid_stream();
        int acc;
        acc = 0;
        idle_inputs();
        tick();
        cfg_beats = 8'd8; cfg_neurons = 10'd1; cfg_op_mode = 1'b1; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 1'b0;
            bias_valid = bias_req;
            dma_valid = dma_ready;
            #1;
            if (mac_en) acc++;
            if (acc == 2) break;
        end
        vectors++;
        if (acc != 2) begin miscompares++; $display("FAIL rst_setup: got %0d expected 2", acc); end
        rst = 1'b1; start = 1'b1;
        tick();
        vectors++;
        if ({busy, out_valid, layer_done, err, dma_ready, mac_en, mac_clr, bias_req, mac_read_en, mac_op_mode} !== 10'd0) begin
            miscompares++;
            $display("FAIL rst_mid_ctrl: got %b expected 0", {busy, out_valid, layer_done, err, dma_ready, mac_en, mac_clr, bias_req, mac_read_en, mac_op_mode});
        end
        rst = 1'b0; start = 1'b0; dma_valid = 1'b0; bias_valid = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_ignored: got %b expected 0", busy); end
        exp_q.push_back({10'd0, 16'h0BEE});
        run_layer(8, 1, 1'b1, 16'h0BEE, 0, 1'b0, 1'b1, 100);
        vectors++;
        if ((vcyc_q.size() > 0 ? vcyc_q[0] : -1) != 14) begin miscompares++; $display("FAIL rst_fresh_latency: got %0d expected 14", vcyc_q.size() > 0 ? vcyc_q[0] : -1); end
        vectors++;
        if (done_err !== 1'b0 || done_cyc < 0) begin miscompares++; $display("FAIL rst_fresh_done: got err=%b cyc=%0d expected err=0", done_err, done_cyc); end
        while (exp_q.size() > 0) begin
            logic [25:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 26'h3FFFFFF;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rst_fresh_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_zero_cfg();
        run_layer(4, 0, 1'b1, 16'h0000, 0, 1'b0, 1'b1, 20);
        vectors++;
        if (done_cyc != 1) begin miscompares++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        vectors++;
        if (done_err !== 1'b1) begin miscompares++; $display("FAIL zero_err: got %b expected 1", done_err); end
        vectors++;
        if (clr_cnt != 0 || n_en != 0 || bias_cnt != 0) begin
            miscompares++;
            $display("FAIL zero_no_ctrl: got clr=%0d en=%0d bias=%0d expected 0/0/0", clr_cnt, n_en, bias_cnt);
        end
    endtask

    task automatic test_min_latency();
        exp_q.push_back({10'd0, 16'h7777});
        run_layer(1, 1, 1'b0, 16'h7777, 0, 1'b0, 1'b1, 50);
        vectors++;
        if ((vcyc_q.size() > 0 ? vcyc_q[0] : -1) != 7) begin miscompares++; $display("FAIL min_latency: got %0d expected 7", vcyc_q.size() > 0 ? vcyc_q[0] : -1); end
        vectors++;
        if (done_err !== 1'b0) begin miscompares++; $display("FAIL min_err_cleared: got %b expected 0", done_err); end
        while (exp_q.size() > 0) begin
            logic [25:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 26'h3FFFFFF;
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL min_word: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_toggle();
        test_backpressure();
        test_watchdog();
        test_reset_mid_stream();
        test_zero_cfg();
        test_min_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
